// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller and fetch/decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

   localparam int REG_ADDR_W  = 5;
   localparam int DRAIN_CNT_W = 4;

   // Canonical NOP (addi x0,x0,0); fetch/decode inserts it when ID/EX is bubbled.
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: decode sources against the load currently in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the stall/bubble equations in pipeline_ctrl.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic                  dec_valid_i,
   input  logic [REG_ADDR_W-1:0] dec_rs1_i,
   input  logic [REG_ADDR_W-1:0] dec_rs2_i,
   input  logic                  dec_uses_rs1_i,
   input  logic                  dec_uses_rs2_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_load_i,
   output logic                  load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   // x0 is never a real dependency; unused sources never cause a stall.
   assign rs1_hit    = dec_uses_rs1_i & (dec_rs1_i == ex_rd_i);
   assign rs2_hit    = dec_uses_rs2_i & (dec_rs2_i == ex_rd_i);
   assign load_use_o = dec_valid_i & ex_load_i & (ex_rd_i != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: load-use interlock, memory freeze, halt drain.
// Latency: stall/bubble/freeze combinational from inputs + state; counters registered.
// Backpressure: mem_busy freezes everything (except cycle_count); load_use defers halt.
// Optional feature: define PIPELINE_CTRL_PERF_EN to build the cycle/stall counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   // Unfrozen cycles from halt acceptance to halted (EX, MEM, WB retire); legal 1..15.
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic                  dec_uses_rs1,
   input  logic                  dec_uses_rs2,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   input  logic                  dec_reg_wrenable,
   input  logic                  dec_mem_to_reg,
   input  logic                  dec_halt,
   input  logic                  mem_busy,
   output logic                  should_stall,
   output logic                  idex_bubble,
   output logic                  pipe_freeze,
   output logic                  halted,
   output logic [31:0]           cycle_count,
   output logic [31:0]           stall_count
);

   pc_state_e               state_q;
   logic [DRAIN_CNT_W-1:0]  drain_cnt_q;
   logic [REG_ADDR_W-1:0]   ex_rd_q;
   logic [REG_ADDR_W-1:0]   ex_rd_d;
   logic                    ex_load_q;
   logic                    ex_load_d;
   logic                    load_use;
   logic                    not_run;
   logic                    halt_accept;

   hazard_detect u_hazard_detect (
      .dec_valid_i    (dec_valid),
      .dec_rs1_i      (dec_rs1),
      .dec_rs2_i      (dec_rs2),
      .dec_uses_rs1_i (dec_uses_rs1),
      .dec_uses_rs2_i (dec_uses_rs2),
      .ex_rd_i        (ex_rd_q),
      .ex_load_i      (ex_load_q),
      .load_use_o     (load_use)
   );

   assign not_run      = (state_q != RUN);
   assign pipe_freeze  = mem_busy;
   assign should_stall = mem_busy | load_use | not_run;
   assign idex_bubble  = ~mem_busy & (load_use | not_run);
   assign halted       = (state_q == HALTED);

   // Halt issues only from RUN, unfrozen, and never on top of a load-use stall.
   assign halt_accept  = (state_q == RUN) & dec_valid & dec_halt & ~load_use & ~mem_busy;

   // Next shadow of the ID/EX register: a bubble or empty decode never carries a load.
   always_comb begin
      ex_rd_d   = ex_rd_q;
      ex_load_d = 1'b0;
      if (!idex_bubble && dec_valid) begin
         ex_rd_d   = dec_rd;
         ex_load_d = dec_mem_to_reg & dec_reg_wrenable;
      end
   end

   // Shadow EX state tracks ID/EX and holds while the pipeline is frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rd_q   <= '0;
         ex_load_q <= 1'b0;
      end else if (!mem_busy) begin
         ex_rd_q   <= ex_rd_d;
         ex_load_q <= ex_load_d;
      end
   end

   // Run/drain/halt sequencing with the drain counter; frozen cycles do not count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
      end else if (!mem_busy) begin
         case (state_q)
            RUN: begin
               if (halt_accept) begin
                  state_q     <= DRAIN;
                  drain_cnt_q <= DRAIN_CNT_W'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               drain_cnt_q <= drain_cnt_q - 1'b1;
               if (drain_cnt_q == DRAIN_CNT_W'(1)) begin
                  state_q <= HALTED;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
            default: begin
               state_q     <= RUN;
               drain_cnt_q <= '0;
            end
         endcase
      end
   end

`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q;
   logic [31:0] stall_cnt_q;

   // Cycle counter runs until halted (even when frozen); stall counter counts RUN
   // stall edges that are not memory freezes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q != HALTED) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
         end
         if (should_stall && (state_q == RUN) && !mem_busy) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign cycle_count = cycle_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   assign cycle_count = 32'd0;
   assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops one entry per cycle and compares every output.
// Counter expectations collapse to zero when PIPELINE_CTRL_PERF_EN is undefined.
module tb_pipeline_ctrl;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic        dec_uses_rs1;
   logic        dec_uses_rs2;
   logic [4:0]  dec_rd;
   logic        dec_reg_wrenable;
   logic        dec_mem_to_reg;
   logic        dec_halt;
   logic        mem_busy;
   logic        should_stall;
   logic        idex_bubble;
   logic        pipe_freeze;
   logic        halted;
   logic [31:0] cycle_count;
   logic [31:0] stall_count;

   typedef struct packed {
      logic        ss;
      logic        bub;
      logic        frz;
      logic        hlt;
      logic [31:0] cyc;
      logic [31:0] stl;
   } exp_t;

   exp_t  sb_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
      .clk              (clk),
      .rst              (rst),
      .dec_valid        (dec_valid),
      .dec_rs1          (dec_rs1),
      .dec_rs2          (dec_rs2),
      .dec_uses_rs1     (dec_uses_rs1),
      .dec_uses_rs2     (dec_uses_rs2),
      .dec_rd           (dec_rd),
      .dec_reg_wrenable (dec_reg_wrenable),
      .dec_mem_to_reg   (dec_mem_to_reg),
      .dec_halt         (dec_halt),
      .mem_busy         (mem_busy),
      .should_stall     (should_stall),
      .idex_bubble      (idex_bubble),
      .pipe_freeze      (pipe_freeze),
      .halted           (halted),
      .cycle_count      (cycle_count),
      .stall_count      (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pc(input logic [31:0] v);
`ifdef PIPELINE_CTRL_PERF_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t  e;
         string nm;
         e  = sb_q.pop_front();
         nm = name_q.pop_front();
         chk(nm, "should_stall", {31'd0, should_stall}, {31'd0, e.ss});
         chk(nm, "idex_bubble",  {31'd0, idex_bubble},  {31'd0, e.bub});
         chk(nm, "pipe_freeze",  {31'd0, pipe_freeze},  {31'd0, e.frz});
         chk(nm, "halted",       {31'd0, halted},       {31'd0, e.hlt});
         chk(nm, "cycle_count",  cycle_count, e.cyc);
         chk(nm, "stall_count",  stall_count, e.stl);
      end
   end

   task automatic dec(input logic dv, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic wr, input logic m2r, input logic hlt);
      dec_valid        = dv;
      dec_rs1          = rs1;
      dec_uses_rs1     = u1;
      dec_rs2          = rs2;
      dec_uses_rs2     = u2;
      dec_rd           = rd;
      dec_reg_wrenable = wr;
      dec_mem_to_reg   = m2r;
      dec_halt         = hlt;
   endtask

   task automatic idle();
      dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Push the expectation for the current cycle, then advance past the next edge.
   task automatic step(input string nm, input logic ss, input logic bub, input logic frz,
                       input logic hlt, input int cyc, input int stl);
      exp_t e;
      e.ss  = ss;
      e.bub = bub;
      e.frz = frz;
      e.hlt = hlt;
      e.cyc = pc(32'(cyc));
      e.stl = pc(32'(stl));
      sb_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      mem_busy = 1'b0;
      idle();
      @(posedge clk);
      #1;
      step("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Load-use on rs1, x0 and unused-source cases, load-use on rs2.
      dec(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);   step("ld5",          0, 0, 0, 0, 0, 0);
      dec(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);   step("lu_rs1_stall", 1, 1, 0, 0, 1, 0);
                                                 step("lu_rs1_issue", 0, 0, 0, 0, 2, 1);
      dec(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0);   step("ld_x0",        0, 0, 0, 0, 3, 1);
      dec(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0);   step("use_x0",       0, 0, 0, 0, 4, 1);
      dec(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0);   step("ld7",          0, 0, 0, 0, 5, 1);
      dec(1, 5'd3, 1, 5'd7, 0, 5'd8, 1, 0, 0);   step("unused_rs2",   0, 0, 0, 0, 6, 1);
      dec(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);   step("ld9",          0, 0, 0, 0, 7, 1);
      dec(1, 5'd1, 1, 5'd9, 1, 5'd10, 1, 0, 0);  step("lu_rs2_stall", 1, 1, 0, 0, 8, 1);
                                                 step("lu_rs2_issue", 0, 0, 0, 0, 9, 2);
      idle();                                    step("perf_10",      0, 0, 0, 0, 10, 2);

      // Freeze for 3 cycles while a load-use is pending, then exactly one bubble.
      dec(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0);   step("ld4",          0, 0, 0, 0, 11, 2);
      dec(1, 5'd4, 1, 5'd0, 0, 5'd11, 1, 0, 0);
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("frz_hold", 1, 0, 1, 0, 12 + i, 2);
      end
      mem_busy = 1'b0;
      step("frz_bubble", 1, 1, 0, 0, 15, 2);
      step("frz_issue",  0, 0, 0, 0, 16, 3);

      // Halt colliding with load-use, then a drain stretched by 2 frozen cycles.
      dec(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 0);  step("ld12",         0, 0, 0, 0, 17, 3);
      dec(1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 0, 1);  step("halt_lu",      1, 1, 0, 0, 18, 3);
                                                 step("halt_accept",  0, 0, 0, 0, 19, 4);
      dec(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0);   step("drain1",       1, 1, 0, 0, 20, 4);
      mem_busy = 1'b1;
      step("drain_frz1", 1, 0, 1, 0, 21, 4);
      step("drain_frz2", 1, 0, 1, 0, 22, 4);
      mem_busy = 1'b0;
      step("drain2",     1, 1, 0, 0, 23, 4);
      step("drain3",     1, 1, 0, 0, 24, 4);
      idle();
      step("halted",     1, 1, 0, 1, 25, 4);
      step("halted_hold",1, 1, 0, 1, 25, 4);
      mem_busy = 1'b1;
      step("halted_frz", 1, 0, 1, 1, 25, 4);
      mem_busy = 1'b0;

      // Reset out of HALTED, then reset in DRAIN after one edge.
      rst = 1'b1;                                step("rst_halted",   0, 0, 0, 0, 0, 0);
      rst = 1'b0;                                step("post_rst",     0, 0, 0, 0, 0, 0);
      dec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);   step("halt2",        0, 0, 0, 0, 1, 0);
      idle();                                    step("drain_a",      1, 1, 0, 0, 2, 0);
      rst = 1'b1;                                step("rst_drain",    0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      dec(1, 5'd5, 1, 5'd0, 0, 5'd1, 1, 0, 0);   step("resume",       0, 0, 0, 0, 0, 0);

      // Plain drain of exactly 3 unfrozen edges; counters stop once halted.
      dec(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);   step("halt3",        0, 0, 0, 0, 1, 0);
      idle();
      step("d1",          1, 1, 0, 0, 2, 0);
      step("d2",          1, 1, 0, 0, 3, 0);
      step("d3",          1, 1, 0, 0, 4, 0);
      step("halted3",     1, 1, 0, 1, 5, 0);
      step("halted3_hold",1, 1, 0, 1, 5, 0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (sb_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_scoreboard: got %0d pending expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage pipelined CPU. It watches the instruction currently in decode and the one just issued to execute. From these it produces the stall and bubble controls that fetch/decode and the ID/EX register consume: load-use interlock, whole-pipeline freeze on memory wait, and an orderly halt drain. It sits beside fetch/decode, and its `should_stall` output drives that stage's `should_stall` input directly.

## Interface
- `DRAIN_CYCLES`, default 3: unfrozen cycles between halt acceptance and `halted` (EX, MEM, WB retire). Legal range 1..15.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `dec_valid` in 1: decode holds a real instruction, not a bubble.
- `dec_rs1`, `dec_rs2` in 5 each: decoded source registers.
- `dec_uses_rs1`, `dec_uses_rs2` in 1 each: the instruction actually reads that source.
- `dec_rd` in 5: decoded destination.
- `dec_reg_wrenable` in 1: instruction writes `dec_rd`.
- `dec_mem_to_reg` in 1: instruction is a load.
- `dec_halt` in 1: decoded instruction is halt.
- `mem_busy` in 1: data memory not ready; the whole pipeline must hold.
- `should_stall` out 1: hold PC and IF/ID.
- `idex_bubble` out 1: ID/EX loads NOP (`32'h00000013` semantics: no writes).
- `pipe_freeze` out 1: every stage register holds.
- `halted` out 1: drain complete; sticky until `rst`.
- `cycle_count` out 32: performance counter (see Configuration).
- `stall_count` out 32: performance counter (see Configuration).

## Operation
- **Shadow EX state.** Registers `ex_rd[4:0]` and `ex_load`.
  - Updated on every clock edge where `pipe_freeze` = 0.
  - If `idex_bubble` or `!dec_valid`: `ex_load` ← 0.
  - Otherwise: `ex_rd` ← `dec_rd` and `ex_load` ← `dec_mem_to_reg & dec_reg_wrenable`.
  - Both hold while frozen.
- **Load-use detection** (combinational): `load_use = dec_valid & ex_load & (ex_rd != 0) & ((dec_uses_rs1 & dec_rs1 == ex_rd) | (dec_uses_rs2 & dec_rs2 == ex_rd))`.
  - ALU results are forwarded elsewhere; only load-use stalls.
- **Output equations:**
  - `pipe_freeze = mem_busy`.
  - `should_stall = mem_busy | load_use | (state != RUN)`.
  - `idex_bubble = !mem_busy & (load_use | state != RUN)`.
- **FSM.** States are RUN, DRAIN and HALTED; the reset state is RUN.
  - RUN → DRAIN when `dec_valid & dec_halt & !load_use & !mem_busy`. The drain counter loads `DRAIN_CYCLES`. The halt instruction itself issues on that edge.
  - DRAIN: the counter decrements on each unfrozen edge. It moves to HALTED on the edge where the counter equals 1.
  - HALTED: absorbing. Only `rst` leaves it.
- **Priority.**
  - `mem_busy` overrides everything: no state, shadow or counter change except `cycle_count`.
  - `load_use` defers halt acceptance.
  - A halt that collides with a load-use hazard stalls one cycle, then is accepted.
- **Decode inputs ignored.** In DRAIN and HALTED, decode inputs are ignored and bubbles are injected on every unfrozen cycle.

## Timing
- All outputs except the counters are combinational from the inputs plus registered state. There is no added latency.
- A load-use stall lasts exactly 1 unfrozen cycle. On the following cycle, `ex_load` = 0 (bubble), so `load_use` deasserts.
- `halted` rises on the `DRAIN_CYCLES`-th unfrozen edge after the halt-acceptance edge. Each `mem_busy` cycle in DRAIN extends this by one.
- **Reset** (async, any state, including mid-DRAIN):
  - Registers: state = RUN, `ex_rd` = 0, `ex_load` = 0, drain counter = 0, both counters = 0.
  - Outputs with `mem_busy` = 0: `should_stall` = 0, `idex_bubble` = 0, `pipe_freeze` = 0, `halted` = 0.
- Releasing `rst` mid-stream resumes with no pending hazard.

## Configuration
- **Macro `PIPELINE_CTRL_PERF_EN` defined:**
  - `cycle_count` increments every edge while state != HALTED.
  - `stall_count` increments every edge where `should_stall` = 1 and state = RUN.
  - Both wrap modulo 2^32.
- **Macro undefined:** no counter flops exist, and both outputs are tied to 0.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - the state enum type (RUN/DRAIN/HALTED);
  - `REG_ADDR_W` = 5;
  - `DRAIN_CNT_W` = 4;
  - `NOP_INSTR` = `32'h00000013`, shared with fetch/decode.
- One sub-module, `hazard_detect`. It is purely combinational: inputs are decode sources/uses and `ex_rd`/`ex_load`; the output is `load_use`.
- FSM, shadow registers and counters live in `pipeline_ctrl`.

## Test plan
- **Load-use on rs1.** Load with `dec_rd` = 5 issued, next decode has `rs1` = 5 and `uses_rs1` = 1. Required: `should_stall` = 1 and `idex_bubble` = 1 for exactly 1 cycle, then both 0 with the instruction issuing.
- **x0 and unused source.** Load to x0, then use of x0: no stall. Load to x7, then `rs2` = 7 with `uses_rs2` = 0: no stall.
- **Freeze during hazard.** `mem_busy` = 1 for 3 cycles while `load_use` is pending. Required: `pipe_freeze` = 1 and `idex_bubble` = 0 for 3 cycles with shadow held; then exactly one bubble cycle.
- **Halt drain.** Halt decoded with `DRAIN_CYCLES` = 3. Required: DRAIN for 3 edges with bubbles each cycle, then `halted` = 1 and `should_stall` = 1 permanently. With 2 `mem_busy` cycles mid-drain, `halted` arrives 2 edges later.
- **Reset in DRAIN.** `rst` pulse in DRAIN after 1 edge. Required: immediately state RUN, `halted` = 0, `should_stall` = 0, counters 0.
- **Performance counters.** With the macro, 10 cycles containing 2 load-use stalls give `cycle_count` = 10 and `stall_count` = 2; counters stop once HALTED. Without the macro, both read 0.
